// File: rtl/mult_job_issuer_pkg.sv
// Shared types and helpers for the multiplier job issuer.
package mult_job_issuer_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // Issuer handshake states; S_ERR is terminal until reset.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_ACK       = 3'd3,
    S_RELEASE   = 3'd4,
    S_ERR       = 3'd5
  } state_e;

  // Product width for a given operand width.
  function automatic int res_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/mult_result_slot.sv
// One-entry valid/ready holding register for multiplier products.
// A load always wins over a consume in the same cycle, so a
// simultaneous consume+load keeps the slot full with the new value.
module mult_result_slot #(
  parameter int WIDTH = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Slot occupancy and data: load sets, consume-only clears.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Free when empty, or when the current entry leaves this cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/mult_job_issuer.sv
// Initiator side of the multiplier handshake: accepts operand jobs,
// drives request/acknowledge toward the multiplier, parks each product
// in a one-entry result slot and flags a sticky timeout if the
// multiplier never completes.
module mult_job_issuer
  import mult_job_issuer_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              iJob_Valid,
  input  logic [DATA_WIDTH-1:0]             iJob_A,
  input  logic [DATA_WIDTH-1:0]             iJob_B,
  output logic                              oJob_Ready,
  output logic [DATA_WIDTH-1:0]             oData_A,
  output logic [DATA_WIDTH-1:0]             oData_B,
  output logic                              oValid_Data,
  output logic                              oAcknoledged,
  input  logic                              iIdle,
  input  logic                              iDone,
  input  logic [res_width(DATA_WIDTH)-1:0]  iResult,
  output logic                              oResult_Valid,
  output logic [res_width(DATA_WIDTH)-1:0]  oResult,
  input  logic                              iResult_Ready,
  output logic [COUNT_WIDTH-1:0]            oJob_Count,
  output logic                              oTimeout
);

  localparam int RW = res_width(DATA_WIDTH);
  // Counter only needs to reach TIMEOUT_CYCLES-1: the cycle on which it
  // holds that value is the last one allowed before the error.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                 r_state;
  logic                   r_job_ready;
  logic                   r_valid_data;
  logic                   r_ack;
  logic                   r_timeout;
  logic [DATA_WIDTH-1:0]  r_data_a;
  logic [DATA_WIDTH-1:0]  r_data_b;
  logic [COUNT_WIDTH-1:0] r_job_count;
  logic [TW-1:0]          r_tmo_cnt;

  logic w_accept;
  logic w_capture;
  logic w_slot_free;
  logic w_tmo_hit;

  assign w_accept  = (r_state == S_IDLE) && r_job_ready && iJob_Valid;
  assign w_capture = (r_state == S_WAIT_DONE) && iDone && w_slot_free;
  assign w_tmo_hit = (TIMEOUT_CYCLES > 0) && (r_tmo_cnt == TMO_LAST);

  // Handshake FSM; every output is written from the state being entered.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_job_ready  <= 1'b0;
      r_valid_data <= 1'b0;
      r_ack        <= 1'b0;
      r_timeout    <= 1'b0;
      r_data_a     <= '0;
      r_data_b     <= '0;
      r_job_count  <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      r_job_ready  <= 1'b0;
      r_valid_data <= 1'b0;
      r_ack        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_ISSUE;
            r_valid_data <= 1'b1;
            r_data_a     <= iJob_A;
            r_data_b     <= iJob_B;
            r_tmo_cnt    <= '0;
          end else begin
            r_job_ready  <= iIdle;
          end
        end
        S_ISSUE: begin
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
          if (w_tmo_hit) begin
            r_state   <= S_ERR;
            r_timeout <= 1'b1;
          end else if (!iIdle) begin
            r_state   <= S_WAIT_DONE;
          end else begin
            r_valid_data <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          // A completed product beats the timeout on the same cycle.
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
          if (w_capture) begin
            r_state     <= S_ACK;
            r_ack       <= 1'b1;
            r_job_count <= r_job_count + COUNT_WIDTH'(1);
          end else if (w_tmo_hit) begin
            r_state   <= S_ERR;
            r_timeout <= 1'b1;
          end
        end
        S_ACK: begin
          if (iDone) r_ack   <= 1'b1;
          else       r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (iIdle) begin
            r_state     <= S_IDLE;
            r_job_ready <= 1'b1;
          end
        end
        S_ERR: begin
          r_timeout <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  mult_result_slot #(.WIDTH(RW)) u_slot (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_load  (w_capture),
    .i_data  (iResult),
    .i_ready (iResult_Ready),
    .o_valid (oResult_Valid),
    .o_data  (oResult),
    .o_free  (w_slot_free)
  );

  assign oJob_Ready   = r_job_ready;
  assign oValid_Data  = r_valid_data;
  assign oAcknoledged = r_ack;
  assign oData_A      = r_data_a;
  assign oData_B      = r_data_b;
  assign oJob_Count   = r_job_count;
  assign oTimeout     = r_timeout;

endmodule

// File: tb/tb_mult_job_issuer.sv
// Bench for mult_job_issuer: behavioural multiplier, queue scoreboard of
// expected products, handshake ordering monitor and directed scenarios
// followed by a randomized job stream with random downstream stalls.
module tb_mult_job_issuer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iJob_Valid;
  logic [31:0] iJob_A, iJob_B;
  logic        oJob_Ready;
  logic [31:0] oData_A, oData_B;
  logic        oValid_Data, oAcknoledged;
  logic        iIdle, iDone;
  logic [63:0] iResult;
  logic        oResult_Valid;
  logic [63:0] oResult;
  logic        iResult_Ready;
  logic [15:0] oJob_Count;
  logic        oTimeout;

  always #5 Clock = ~Clock;

  mult_job_issuer #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .COUNT_WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .iJob_Valid(iJob_Valid), .iJob_A(iJob_A), .iJob_B(iJob_B), .oJob_Ready(oJob_Ready),
    .oData_A(oData_A), .oData_B(oData_B), .oValid_Data(oValid_Data),
    .oAcknoledged(oAcknoledged), .iIdle(iIdle), .iDone(iDone), .iResult(iResult),
    .oResult_Valid(oResult_Valid), .oResult(oResult), .iResult_Ready(iResult_Ready),
    .oJob_Count(oJob_Count), .oTimeout(oTimeout)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  int          jobs_since_rst = 0;
  bit          never_done = 0;
  int          ack_hold = 0;
  logic        p_ack = 1'b0, p_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural multiplier: latches operands on request, answers after a
  // random latency, holds Done until acknowledged, then returns to idle.
  int          m_st = 0, m_dly = 0, m_hold = 0;
  logic [63:0] ma, mb;
  initial begin
    iIdle = 1'b1; iDone = 1'b0; iResult = '0;
    forever begin
      @(posedge Clock); #1;
      if (!Reset) begin
        m_st = 0; iIdle = 1'b1; iDone = 1'b0;
      end else begin
        case (m_st)
          0: if (oValid_Data) begin
               ma = 64'(oData_A); mb = 64'(oData_B);
               iIdle = 1'b0; m_dly = $urandom_range(1, 4); m_st = 1;
             end
          1: if (!never_done) begin
               if (m_dly <= 1) begin
                 iDone = 1'b1; iResult = ma * mb; m_hold = ack_hold; m_st = 2;
               end else m_dly--;
             end
          2: if (oAcknoledged) begin
               if (m_hold == 0) begin
                 iDone = 1'b0; m_dly = $urandom_range(0, 2); m_st = 3;
               end else m_hold--;
             end
          default: if (m_dly == 0) begin iIdle = 1'b1; m_st = 0; end else m_dly--;
        endcase
      end
    end
  end

  // Scoreboard and ordering monitor, sampled mid-cycle.
  always @(negedge Clock) begin
    if (!Reset) begin
      sb.delete();
      jobs_since_rst = 0;
    end else begin
      if (iJob_Valid && oJob_Ready) begin
        sb.push_back(64'(iJob_A) * 64'(iJob_B));
        jobs_since_rst++;
      end
      if (oResult_Valid && iResult_Ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) chk("sb_result", oResult, sb.pop_front());
      end
      if (oAcknoledged && !p_ack) chk("ack_rise_after_done", 64'(p_done), 64'd1);
      if (!oAcknoledged && p_ack) chk("ack_fall_after_done_drop", 64'(p_done), 64'd0);
      if (oValid_Data) chk("req_ack_overlap", 64'(oAcknoledged), 64'd0);
    end
    p_ack  = oAcknoledged;
    p_done = iDone;
  end

  task automatic do_reset(input int n);
    @(posedge Clock); #1 Reset = 1'b0;
    repeat (n) @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  task automatic send_job(input logic [31:0] a, input logic [31:0] b);
    bit got = 0;
    @(posedge Clock); #1;
    iJob_Valid = 1'b1; iJob_A = a; iJob_B = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge Clock);
      if (oJob_Ready) begin got = 1; break; end
    end
    chk("job_accepted", 64'(got), 64'd1);
    @(posedge Clock); #1 iJob_Valid = 1'b0;
  endtask

  task automatic wait_rv(input string tag);
    bit got = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge Clock);
      if (oResult_Valid) begin got = 1; break; end
    end
    chk(tag, 64'(got), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit got = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge Clock);
      if (sb.size() == 0) begin got = 1; break; end
    end
    chk(tag, 64'(got), 64'd1);
    repeat (4) @(negedge Clock);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit got;
    bit stop_rdy;
    iJob_Valid = 1'b0; iJob_A = '0; iJob_B = '0; iResult_Ready = 1'b0;

    // Reset held low for three cycles, then released.
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_flags", 64'({oJob_Ready, oValid_Data, oAcknoledged, oResult_Valid, oTimeout}), 64'd0);
    chk("rst_count", 64'(oJob_Count), 64'd0);
    chk("rst_result", oResult, 64'd0);
    chk("rst_operands", {oData_A, oData_B}, 64'd0);
    @(posedge Clock); #1 Reset = 1'b1;
    @(negedge Clock); @(negedge Clock);
    chk("ready_after_rst", 64'(oJob_Ready), 64'd1);

    // Single job held in the slot.
    send_job(32'd7, 32'd6);
    wait_rv("t2_rv_seen");
    chk("t2_result", oResult, 64'd42);
    chk("t2_count", 64'(oJob_Count), 64'd1);
    @(posedge Clock); #1 iResult_Ready = 1'b1;
    wait_drain("t2_drain");

    // Back-to-back jobs with the consumer always ready.
    do_reset(2);
    send_job(32'd3, 32'd9);
    send_job(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_drain("t3_drain");
    chk("t3_count", 64'(oJob_Count), 64'd2);

    // Backpressure: second Done arrives while the slot is still full.
    do_reset(2);
    iResult_Ready = 1'b0;
    send_job(32'd11, 32'd13);
    wait_rv("t4_rv_seen");
    send_job(32'd100, 32'd200);
    got = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge Clock);
      if (iDone) begin got = 1; break; end
    end
    chk("t4_done_seen", 64'(got), 64'd1);
    repeat (3) @(negedge Clock);
    chk("t4_stall_no_ack", 64'(oAcknoledged), 64'd0);
    chk("t4_stall_hold", oResult, 64'd143);
    chk("t4_stall_valid", 64'(oResult_Valid), 64'd1);
    @(posedge Clock); #1 iResult_Ready = 1'b1;
    @(posedge Clock); #1 iResult_Ready = 1'b0;
    @(negedge Clock);
    chk("t4_swap_result", oResult, 64'd20000);
    chk("t4_swap_valid", 64'(oResult_Valid), 64'd1);
    chk("t4_swap_ack", 64'(oAcknoledged), 64'd1);
    @(posedge Clock); #1 iResult_Ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_count", 64'(oJob_Count), 64'd2);

    // Multiplier never completes: timeout after 16 active cycles.
    do_reset(2);
    never_done = 1;
    send_job(32'd5, 32'd5);
    for (int k = 1; k <= 17; k++) begin
      @(negedge Clock);
      if (k == 16) chk("t5_tmo_not_yet", 64'(oTimeout), 64'd0);
      if (k == 17) begin
        chk("t5_tmo_set", 64'(oTimeout), 64'd1);
        chk("t5_err_outs", 64'({oValid_Data, oAcknoledged, oJob_Ready}), 64'd0);
      end
    end
    repeat (5) @(negedge Clock);
    chk("t5_tmo_sticky", 64'({oTimeout, oJob_Ready}), 64'b10);
    never_done = 0;
    do_reset(2);
    @(negedge Clock);
    chk("t5_tmo_cleared", 64'(oTimeout), 64'd0);

    // Reset while acknowledging.
    ack_hold = 3;
    iResult_Ready = 1'b0;
    send_job(32'd9, 32'd9);
    got = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge Clock); #1;
      if (oAcknoledged) begin got = 1; break; end
    end
    chk("t6_ack_seen", 64'(got), 64'd1);
    Reset = 1'b0;
    @(posedge Clock); @(negedge Clock);
    chk("t6_rst_ack", 64'(oAcknoledged), 64'd0);
    chk("t6_rst_rv", 64'(oResult_Valid), 64'd0);
    chk("t6_rst_count", 64'(oJob_Count), 64'd0);
    @(posedge Clock); #1 Reset = 1'b1;
    ack_hold = 0;
    iResult_Ready = 1'b1;
    send_job(32'd8, 32'd8);
    wait_drain("t6_drain");
    chk("t6_count", 64'(oJob_Count), 64'd1);

    // Random job stream with random downstream stalls.
    do_reset(2);
    stop_rdy = 0;
    fork
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 2)) @(posedge Clock);
          send_job(rand_op(), rand_op());
        end
        stop_rdy = 1;
      end
      begin
        for (int c = 0; c < 20000 && !stop_rdy; c++) begin
          @(posedge Clock); #1 iResult_Ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge Clock); #1 iResult_Ready = 1'b1;
    wait_drain("t7_drain");
    chk("t7_count", 64'(oJob_Count), 64'd30);
    chk("t7_jobs_seen", 64'(jobs_since_rst), 64'd30);
    chk("t7_no_tmo", 64'(oTimeout), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
